// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core and the FIR accelerator.
// Optional locked bursts (bounded by MAX_LOCK) are enabled by defining DMEM_ARB_LOCK_EN.
module data_memory_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              coreReqValid,
    input  logic              coreReqWrite,
    input  logic [2:0]        coreReqFunc3,
    input  logic [ADDR_W-1:0] coreReqAddr,
    input  logic [DATA_W-1:0] coreReqWdata,
    output logic              coreReqReady,
    output logic              coreRspValid,
    output logic [DATA_W-1:0] coreRspRdata,
    input  logic              accReqValid,
    input  logic              accReqWrite,
    input  logic [2:0]        accReqFunc3,
    input  logic [ADDR_W-1:0] accReqAddr,
    input  logic [DATA_W-1:0] accReqWdata,
    output logic              accReqReady,
    output logic              accRspValid,
    output logic [DATA_W-1:0] accRspRdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              coreReqLock,
    input  logic              accReqLock,
`endif
    output logic              memoryReadEnable,
    output logic              memoryWriteEnable,
    output logic [2:0]        func3,
    output logic [ADDR_W-1:0] memoryAddress,
    output logic [DATA_W-1:0] writeData,
    input  logic [DATA_W-1:0] readData,
    output logic              grantOwner
);

    logic last_grant;
    logic rr_core;
    logic rr_acc;
    logic grant_core;
    logic grant_acc;
    logic sel_write;

    always_comb begin
        rr_core = coreReqValid && (!accReqValid || last_grant);
        rr_acc  = accReqValid && !rr_core;
    end

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_LIMIT = CNT_W'(MAX_LOCK);

    logic             lock_on;
    logic             lock_port;
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_hold;
    logic             granted_lock;

    // A locked port stays sole candidate until its streak reaches the limit.
    always_comb begin
        lock_hold = lock_on && (lock_cnt < LOCK_LIMIT) &&
                    (lock_port ? (accReqValid && accReqLock) : (coreReqValid && coreReqLock));
        grant_core   = resetN && (lock_hold ? !lock_port : rr_core);
        grant_acc    = resetN && (lock_hold ? lock_port : rr_acc);
        granted_lock = (grant_core && coreReqLock) || (grant_acc && accReqLock);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            lock_on   <= 1'b0;
            lock_port <= 1'b0;
            lock_cnt  <= '0;
        end else if (lock_on && lock_cnt == LOCK_LIMIT) begin
            lock_on  <= 1'b0;
            lock_cnt <= '0;
        end else if (granted_lock) begin
            if (lock_on && lock_port == grant_acc) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end else begin
                lock_on   <= 1'b1;
                lock_port <= grant_acc;
                lock_cnt  <= CNT_W'(1);
            end
        end else begin
            lock_on  <= 1'b0;
            lock_cnt <= '0;
        end
    end
`else
    always_comb begin
        grant_core = resetN && rr_core;
        grant_acc  = resetN && rr_acc;
    end
`endif

    always_comb begin
        coreReqReady      = grant_core;
        accReqReady       = grant_acc;
        sel_write         = grant_core ? coreReqWrite : accReqWrite;
        memoryWriteEnable = (grant_core || grant_acc) && sel_write;
        memoryReadEnable  = (grant_core || grant_acc) && !sel_write;
        func3             = '0;
        memoryAddress     = '0;
        writeData         = '0;
        if (grant_core) begin
            func3         = coreReqFunc3;
            memoryAddress = coreReqAddr;
            writeData     = coreReqWdata;
        end else if (grant_acc) begin
            func3         = accReqFunc3;
            memoryAddress = accReqAddr;
            writeData     = accReqWdata;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            last_grant   <= 1'b1;
            grantOwner   <= 1'b0;
            coreRspValid <= 1'b0;
            accRspValid  <= 1'b0;
            coreRspRdata <= '0;
            accRspRdata  <= '0;
        end else begin
            coreRspValid <= grant_core && !coreReqWrite;
            accRspValid  <= grant_acc && !accReqWrite;
            if (grant_core && !coreReqWrite) coreRspRdata <= readData;
            if (grant_acc && !accReqWrite) accRspRdata <= readData;
            if (grant_core || grant_acc) begin
                last_grant <= grant_acc;
                grantOwner <= grant_acc;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: byte-addressed memory environment, directed
// scenarios with literal expectations and a randomized phase checked by a reference model.
module tb_data_memory_arbiter;

    localparam int unsigned ML = 8;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        coreReqValid = 1'b0, coreReqWrite = 1'b0;
    logic [2:0]  coreReqFunc3 = '0;
    logic [31:0] coreReqAddr = '0, coreReqWdata = '0;
    logic        coreReqReady, coreRspValid;
    logic [31:0] coreRspRdata;
    logic        accReqValid = 1'b0, accReqWrite = 1'b0;
    logic [2:0]  accReqFunc3 = '0;
    logic [31:0] accReqAddr = '0, accReqWdata = '0;
    logic        accReqReady, accRspValid;
    logic [31:0] accRspRdata;
`ifdef DMEM_ARB_LOCK_EN
    logic        coreReqLock = 1'b0, accReqLock = 1'b0;
`endif
    logic        memoryReadEnable, memoryWriteEnable;
    logic [2:0]  func3;
    logic [31:0] memoryAddress, writeData, readData;
    logic        grantOwner;

    int tests = 0;
    int fails = 0;

    data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(ML)) dut (
        .clock(clock), .resetN(resetN),
        .coreReqValid(coreReqValid), .coreReqWrite(coreReqWrite), .coreReqFunc3(coreReqFunc3),
        .coreReqAddr(coreReqAddr), .coreReqWdata(coreReqWdata), .coreReqReady(coreReqReady),
        .coreRspValid(coreRspValid), .coreRspRdata(coreRspRdata),
        .accReqValid(accReqValid), .accReqWrite(accReqWrite), .accReqFunc3(accReqFunc3),
        .accReqAddr(accReqAddr), .accReqWdata(accReqWdata), .accReqReady(accReqReady),
        .accRspValid(accRspValid), .accRspRdata(accRspRdata),
`ifdef DMEM_ARB_LOCK_EN
        .coreReqLock(coreReqLock), .accReqLock(accReqLock),
`endif
        .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
        .func3(func3), .memoryAddress(memoryAddress), .writeData(writeData),
        .readData(readData), .grantOwner(grantOwner)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32 load extraction from the aligned little-endian word.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off, input logic [2:0] f3);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        case (f3)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {{16{s[15]}}, s[15:0]};
            3'd4:    return {24'd0, s[7:0]};
            3'd5:    return {16'd0, s[15:0]};
            default: return w;
        endcase
    endfunction

    // Memory environment driven by the DUT's memory port.
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic [7:0] ea;
    assign ea = memoryAddress[7:0];
    assign readData = extract({mem[{ea[7:2], 2'd3}], mem[{ea[7:2], 2'd2}], mem[{ea[7:2], 2'd1}],
                               mem[{ea[7:2], 2'd0}]}, ea[1:0], func3);

    always @(posedge clock) begin
        if (memoryWriteEnable) begin
            case (func3[1:0])
                2'd0: mem[ea] <= writeData[7:0];
                2'd1: begin
                    mem[ea]        <= writeData[7:0];
                    mem[ea + 8'd1] <= writeData[15:8];
                end
                default: begin
                    mem[{ea[7:2], 2'd0}] <= writeData[7:0];
                    mem[{ea[7:2], 2'd1}] <= writeData[15:8];
                    mem[{ea[7:2], 2'd2}] <= writeData[23:16];
                    mem[{ea[7:2], 2'd3}] <= writeData[31:24];
                end
            endcase
        end
    end

    // Reference model: owner of each cycle's transfer and the responses it must produce.
    logic        m_last = 1'b1, m_owner = 1'b0;
    logic        m_crv = 1'b0, m_arv = 1'b0;
    logic [31:0] m_crd = '0, m_ard = '0;
    logic        m_lk_on = 1'b0, m_lk_acc = 1'b0;
    int          m_lk_n = 0;

    always @(negedge clock) begin
        int          g;
        logic        wr, lk, held;
        logic [2:0]  f3;
        logic [31:0] ad, wd, val;
        logic [7:0]  a8;
        if (!resetN) begin
            check("rst_core_ready", {31'd0, coreReqReady}, 32'd0);
            check("rst_acc_ready", {31'd0, accReqReady}, 32'd0);
            check("rst_enables", {30'd0, memoryReadEnable, memoryWriteEnable}, 32'd0);
            check("rst_rsp_valid", {30'd0, coreRspValid, accRspValid}, 32'd0);
            check("rst_core_rdata", coreRspRdata, 32'd0);
            check("rst_acc_rdata", accRspRdata, 32'd0);
            check("rst_owner", {31'd0, grantOwner}, 32'd0);
            m_last = 1'b1; m_owner = 1'b0; m_crv = 1'b0; m_arv = 1'b0;
            m_crd = '0; m_ard = '0; m_lk_on = 1'b0; m_lk_n = 0;
        end else begin
            check("core_rsp_valid", {31'd0, coreRspValid}, {31'd0, m_crv});
            check("acc_rsp_valid", {31'd0, accRspValid}, {31'd0, m_arv});
            check("core_rsp_rdata", coreRspRdata, m_crd);
            check("acc_rsp_rdata", accRspRdata, m_ard);
            check("grant_owner", {31'd0, grantOwner}, {31'd0, m_owner});
            g = 0;
            held = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
            held = m_lk_on && m_lk_n < ML &&
                   (m_lk_acc ? (accReqValid && accReqLock) : (coreReqValid && coreReqLock));
            if (held) g = m_lk_acc ? 2 : 1;
`endif
            if (!held) begin
                if (coreReqValid && accReqValid) g = m_last ? 1 : 2;
                else if (coreReqValid) g = 1;
                else if (accReqValid) g = 2;
            end
            wr = 1'b0; lk = 1'b0; f3 = '0; ad = '0; wd = '0;
            if (g == 1) begin
                wr = coreReqWrite; f3 = coreReqFunc3; ad = coreReqAddr; wd = coreReqWdata;
`ifdef DMEM_ARB_LOCK_EN
                lk = coreReqLock;
`endif
            end else if (g == 2) begin
                wr = accReqWrite; f3 = accReqFunc3; ad = accReqAddr; wd = accReqWdata;
`ifdef DMEM_ARB_LOCK_EN
                lk = accReqLock;
`endif
            end
            check("core_ready", {31'd0, coreReqReady}, {31'd0, g == 1});
            check("acc_ready", {31'd0, accReqReady}, {31'd0, g == 2});
            check("write_enable", {31'd0, memoryWriteEnable}, {31'd0, g != 0 && wr});
            check("read_enable", {31'd0, memoryReadEnable}, {31'd0, g != 0 && !wr});
            check("func3", {29'd0, func3}, {29'd0, f3});
            check("address", memoryAddress, ad);
            check("write_data", writeData, wd);
            m_crv = 1'b0;
            m_arv = 1'b0;
            if (g != 0) begin
                a8 = ad[7:0];
                if (wr) begin
                    if (f3[1:0] == 2'd0) ref_mem[a8] = wd[7:0];
                    else if (f3[1:0] == 2'd1) begin
                        ref_mem[a8] = wd[7:0];
                        ref_mem[a8 + 8'd1] = wd[15:8];
                    end else begin
                        for (int k = 0; k < 4; k++) ref_mem[{a8[7:2], 2'd0} + 8'(k)] = wd[8*k +: 8];
                    end
                end else begin
                    val = extract({ref_mem[{a8[7:2], 2'd3}], ref_mem[{a8[7:2], 2'd2}],
                                   ref_mem[{a8[7:2], 2'd1}], ref_mem[{a8[7:2], 2'd0}]}, a8[1:0], f3);
                    if (g == 1) begin m_crv = 1'b1; m_crd = val; end
                    else begin m_arv = 1'b1; m_ard = val; end
                end
                m_last  = (g == 2);
                m_owner = (g == 2);
            end
            // A streak that hit the limit gives up exactly one arbitration, then restarts from zero.
            if (m_lk_on && m_lk_n == ML) begin
                m_lk_on = 1'b0; m_lk_n = 0;
            end else if (g != 0 && lk) begin
                if (m_lk_on && m_lk_acc == (g == 2)) m_lk_n++;
                else begin m_lk_on = 1'b1; m_lk_acc = (g == 2); m_lk_n = 1; end
            end else begin
                m_lk_on = 1'b0; m_lk_n = 0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rnd(output logic w, output logic [2:0] f3, output logic [31:0] a, output logic [31:0] d);
        logic [2:0] loads [0:4];
        loads = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        w  = 1'($urandom_range(0, 1));
        f3 = w ? 3'($urandom_range(0, 2)) : loads[$urandom_range(0, 4)];
        a  = $urandom();
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        d  = $urandom();
    endtask

    initial begin
        logic [11:0] pat;
        logic        ct, at;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 37 + 11);
            ref_mem[i] = 8'(i * 37 + 11);
        end
        // Reset held while both request, then release: strict alternation starting with the core.
        coreReqValid = 1'b1; coreReqWrite = 1'b0; coreReqFunc3 = 3'd2; coreReqAddr = 32'h40;
        accReqValid = 1'b1; accReqWrite = 1'b0; accReqFunc3 = 3'd2; accReqAddr = 32'h80;
        repeat (3) step();
        resetN = 1'b1;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            pat = {pat[9:0], coreReqReady, accReqReady};
        end
        check("alternation_CACACA", {20'd0, pat}, {20'd0, 12'b10_01_10_01_10_01});
        step();
        accReqValid = 1'b0;
        coreReqWrite = 1'b1; coreReqAddr = 32'h10; coreReqWdata = 32'hDEADBEEF;
        @(negedge clock);
        step();
        coreReqWrite = 1'b0; coreReqWdata = '0;
        @(negedge clock);
        step();
        coreReqValid = 1'b0;
        @(negedge clock);
        check("lw_rsp_valid", {31'd0, coreRspValid}, 32'd1);
        check("lw_rsp_rdata", coreRspRdata, 32'hDEADBEEF);
        // Sign-extending byte load of 0xF0.
        step();
        coreReqValid = 1'b1; coreReqWrite = 1'b1; coreReqFunc3 = 3'd2; coreReqAddr = 32'h20;
        coreReqWdata = 32'h000000F0;
        @(negedge clock);
        step();
        coreReqWrite = 1'b0; coreReqFunc3 = 3'd0; coreReqWdata = '0;
        @(negedge clock);
        check("lb_func3", {29'd0, func3}, 32'd0);
        check("lb_read_en", {31'd0, memoryReadEnable}, 32'd1);
        step();
        coreReqValid = 1'b0;
        @(negedge clock);
        check("lb_rsp_rdata", coreRspRdata, 32'hFFFFFFF0);
        // Reset right after a read accept discards the response.
        step();
        coreReqValid = 1'b1; coreReqFunc3 = 3'd2; coreReqAddr = 32'h10;
        @(negedge clock);
        step();
        resetN = 1'b0; coreReqValid = 1'b0;
        @(negedge clock);
        step();
        resetN = 1'b1;
        @(negedge clock);
        check("post_rst_rsp_valid", {31'd0, coreRspValid}, 32'd0);
        check("post_rst_rsp_rdata", coreRspRdata, 32'd0);
        // Randomized traffic; a pending request keeps its fields until accepted or withdrawn.
        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            ct = coreReqValid && coreReqReady;
            at = accReqValid && accReqReady;
            step();
            if (!coreReqValid || ct) begin
                if ($urandom_range(0, 3) != 0) begin
                    rnd(coreReqWrite, coreReqFunc3, coreReqAddr, coreReqWdata);
                    coreReqValid = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
                    coreReqLock = 1'($urandom_range(0, 1));
`endif
                end else coreReqValid = 1'b0;
            end else if ($urandom_range(0, 7) == 0) coreReqValid = 1'b0;
            if (!accReqValid || at) begin
                if ($urandom_range(0, 3) != 0) begin
                    rnd(accReqWrite, accReqFunc3, accReqAddr, accReqWdata);
                    accReqValid = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
                    accReqLock = 1'($urandom_range(0, 1));
`endif
                end else accReqValid = 1'b0;
            end else if ($urandom_range(0, 7) == 0) accReqValid = 1'b0;
        end
        @(negedge clock);
        step();
        coreReqValid = 1'b0; accReqValid = 1'b0;
        @(negedge clock);
`ifdef DMEM_ARB_LOCK_EN
        // Core store first so the accelerator wins the next contended arbitration.
        step();
        coreReqValid = 1'b1; coreReqWrite = 1'b1; coreReqFunc3 = 3'd2; coreReqAddr = 32'h30;
        coreReqLock = 1'b0;
        @(negedge clock);
        step();
        coreReqWrite = 1'b0;
        accReqValid = 1'b1; accReqWrite = 1'b0; accReqFunc3 = 3'd2; accReqAddr = 32'h84; accReqLock = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            check($sformatf("lock_seq_acc_%0d", i), {31'd0, accReqReady}, {31'd0, i != 8});
        end
        step();
        coreReqValid = 1'b0; accReqValid = 1'b0; accReqLock = 1'b0;
        @(negedge clock);
`endif
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
